// File: rtl/register_file.sv
// Purpose : 32-entry RV32I general-purpose register file, x0 hardwired to zero.
// Latency : reads are combinational (0 cycles); a write is visible after the rising clk edge.
// Backpressure: none; every write presented with write_enable high is accepted on the edge.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset (clears all registers)
//   rs1_addr, rs2_addr    read port indices
//   read_data1/2          combinational contents of the addressed registers
//   rd_addr, write_data,
//   write_enable          synchronous write port fed by the writeback mux
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  // Entry 0 exists only so every index is in range; it is reset and never written.
  logic [DATA_WIDTH-1:0] regs [0:NUM_REGS-1];

  // The asynchronous clear wins over any write on a coincident edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_enable && (rd_addr != '0)) begin
      regs[rd_addr] <= write_data;
    end
  end

  // No write bypass: a same-cycle read of rd_addr returns the old value until the edge.
  assign read_data1 = (rs1_addr == '0) ? '0 : regs[rs1_addr];
  assign read_data2 = (rs2_addr == '0) ? '0 : regs[rs2_addr];

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int checks;
  int errors;
  bit done;

  // Architectural view of the register file: 32 words, x0 always reads 0.
  logic [31:0] mdl [32];

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rd_addr      (rd_addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .read_data1   (read_data1),
    .read_data2   (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : mdl[a];
  endfunction

  // Model update: a reset clears everything at once; otherwise an enabled
  // write to a non-zero index lands on the rising edge.
  always @(negedge rst_n) begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    end else if (write_enable === 1'b1 && rd_addr != 5'd0) begin
      mdl[rd_addr] = write_data;
    end
  end

  // Continuous comparison on the falling edge, when inputs and outputs are stable.
  initial begin
    @(negedge clk);
    while (!done) begin
      chk("cmp_rd1", read_data1, expect_rd(rs1_addr));
      chk("cmp_rd2", read_data2, expect_rd(rs2_addr));
      @(negedge clk);
    end
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    #2;
    rd_addr      = a;
    write_data   = d;
    write_enable = 1'b1;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
  endtask

  task automatic sweep_zero(input string name);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      chk({name, "_p1"}, read_data1, 32'h0);
      chk({name, "_p2"}, read_data2, 32'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    checks       = 0;
    errors       = 0;
    done         = 1'b0;
    rst_n        = 1'b0;
    rs1_addr     = 5'd0;
    rs2_addr     = 5'd0;
    rd_addr      = 5'd1;
    write_data   = 32'hFFFF_FFFF;
    write_enable = 1'b1;   // writes must be ignored while in reset

    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    write_enable = 1'b0;
    rst_n        = 1'b1;

    // 1. Everything reads zero after reset.
    sweep_zero("reset");

    // 2. Basic write/read on both ports.
    wr(5'd5, 32'hDEAD_BEEF);
    rs1_addr = 5'd5;
    rs2_addr = 5'd5;
    #1;
    chk("x5_p1", read_data1, 32'hDEAD_BEEF);
    chk("x5_p2", read_data2, 32'hDEAD_BEEF);
    rs1_addr = 5'd6;
    rs2_addr = 5'd4;
    #1;
    chk("x6_zero", read_data1, 32'h0);
    chk("x4_zero", read_data2, 32'h0);

    // 3. Writes to x0 are discarded.
    wr(5'd0, 32'hFFFF_FFFF);
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    #1;
    chk("x0_p1", read_data1, 32'h0);
    chk("x0_p2", read_data2, 32'h0);

    // 4. write_enable low leaves the register untouched.
    wr(5'd7, 32'h1234_5678);
    @(negedge clk);
    #2;
    rd_addr      = 5'd7;
    write_data   = 32'hAAAA_AAAA;
    write_enable = 1'b0;
    @(posedge clk);
    #1;
    rs1_addr = 5'd7;
    rs2_addr = 5'd5;
    #1;
    chk("x7_hold", read_data1, 32'h1234_5678);
    chk("x5_still", read_data2, 32'hDEAD_BEEF);

    // 5. Read during write to the same register: old value before, new after.
    wr(5'd9, 32'h1);
    @(negedge clk);
    #2;
    rs1_addr     = 5'd9;
    rs2_addr     = 5'd9;
    rd_addr      = 5'd9;
    write_data   = 32'h2;
    write_enable = 1'b1;
    #1;
    chk("x9_before", read_data1, 32'h1);
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    chk("x9_after", read_data1, 32'h2);
    chk("x9_after_p2", read_data2, 32'h2);

    // 6. Fill x1..x31 with their index, then reset asynchronously mid-cycle.
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    rs1_addr = 5'd31;
    rs2_addr = 5'd17;
    #1;
    chk("fill_x31", read_data1, 32'd31);
    chk("fill_x17", read_data2, 32'd17);
    @(negedge clk);
    #2;
    rd_addr      = 5'd3;
    write_data   = 32'h0000_0BAD;
    write_enable = 1'b1;
    rst_n        = 1'b0;
    #1;
    chk("arst_x31", read_data1, 32'h0);
    chk("arst_x17", read_data2, 32'h0);
    @(posedge clk);
    #1;
    chk("arst_edge_x31", read_data1, 32'h0);
    @(negedge clk);
    #2;
    write_enable = 1'b0;
    rst_n        = 1'b1;
    rs1_addr     = 5'd3;
    #1;
    chk("arst_no_write_x3", read_data1, 32'h0);
    sweep_zero("post_arst");

    // First edge after release writes normally.
    wr(5'd12, 32'hCAFE_F00D);
    rs1_addr = 5'd12;
    rs2_addr = 5'd0;
    #1;
    chk("post_rel_x12", read_data1, 32'hCAFE_F00D);
    chk("post_rel_x0", read_data2, 32'h0);

    @(negedge clk);
    done = 1'b1;
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
